dtm: RTL and testbench

//  JTAG Debug Transport Module. Sits directly upstream of the debug module (dm) and drives its DMI request port.

---
 rtl/dtm_pkg.sv | 73 +++++++
 rtl/dtm_jtag_tap_fsm.sv | 72 +++++++
 rtl/dtm.sv | 197 +++++++++++++++++++
 tb/tb_dtm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtm_pkg.sv
// Shared definitions for the JTAG debug transport module: IR codes, DMI op and
// status encodings, TAP state encodings and the IR-to-DR decode helper.
package dtm_defs;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_STAT_OK     = 2'd0;
    localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

    localparam logic [3:0] TAP_TLR        = 4'hF;
    localparam logic [3:0] TAP_RTI        = 4'hC;
    localparam logic [3:0] TAP_SELECT_DR  = 4'h7;
    localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
    localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
    localparam logic [3:0] TAP_EXIT1_DR   = 4'h1;
    localparam logic [3:0] TAP_PAUSE_DR   = 4'h3;
    localparam logic [3:0] TAP_EXIT2_DR   = 4'h0;
    localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
    localparam logic [3:0] TAP_SELECT_IR  = 4'h4;
    localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
    localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
    localparam logic [3:0] TAP_EXIT1_IR   = 4'h9;
    localparam logic [3:0] TAP_PAUSE_IR   = 4'hB;
    localparam logic [3:0] TAP_EXIT2_IR   = 4'h8;
    localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;

    typedef enum logic [3:0] {
        ST_TLR        = TAP_TLR,
        ST_RTI        = TAP_RTI,
        ST_SELECT_DR  = TAP_SELECT_DR,
        ST_CAPTURE_DR = TAP_CAPTURE_DR,
        ST_SHIFT_DR   = TAP_SHIFT_DR,
        ST_EXIT1_DR   = TAP_EXIT1_DR,
        ST_PAUSE_DR   = TAP_PAUSE_DR,
        ST_EXIT2_DR   = TAP_EXIT2_DR,
        ST_UPDATE_DR  = TAP_UPDATE_DR,
        ST_SELECT_IR  = TAP_SELECT_IR,
        ST_CAPTURE_IR = TAP_CAPTURE_IR,
        ST_SHIFT_IR   = TAP_SHIFT_IR,
        ST_EXIT1_IR   = TAP_EXIT1_IR,
        ST_PAUSE_IR   = TAP_PAUSE_IR,
        ST_EXIT2_IR   = TAP_EXIT2_IR,
        ST_UPDATE_IR  = TAP_UPDATE_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_DTMCS,
        DR_DMI
    } dr_sel_e;

    // Any instruction code we do not implement falls back to the 1-bit bypass register.
    function automatic dr_sel_e decode_ir(input logic [4:0] ir);
        dr_sel_e sel;
        case (ir)
            IR_IDCODE: sel = DR_IDCODE;
            IR_DTMCS:  sel = DR_DTMCS;
            IR_DMI:    sel = DR_DMI;
            default:   sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dtm_jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller clocked by clk and advanced by the synchronised
// tck_rise pulse. Capture/shift/update strobes fire on the tck_rise that leaves
// the corresponding state, so they last exactly one clk.
module jtag_tap_fsm
    import dtm_defs::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       tck_rise,
    input  logic       tms,
    output logic [3:0] state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register; reset parks the TAP in Test-Logic-Reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TMS-driven next-state walk plus the per-state action strobes.
    always_comb begin
        state_d    = state_q;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        if (tck_rise) begin
            capture_ir = (state_q == ST_CAPTURE_IR);
            shift_ir   = (state_q == ST_SHIFT_IR);
            update_ir  = (state_q == ST_UPDATE_IR);
            capture_dr = (state_q == ST_CAPTURE_DR);
            shift_dr   = (state_q == ST_SHIFT_DR);
            update_dr  = (state_q == ST_UPDATE_DR);
            case (state_q)
                ST_TLR:        state_d = tms ? ST_TLR        : ST_RTI;
                ST_RTI:        state_d = tms ? ST_SELECT_DR  : ST_RTI;
                ST_SELECT_DR:  state_d = tms ? ST_SELECT_IR  : ST_CAPTURE_DR;
                ST_CAPTURE_DR: state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
                ST_SHIFT_DR:   state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
                ST_EXIT1_DR:   state_d = tms ? ST_UPDATE_DR  : ST_PAUSE_DR;
                ST_PAUSE_DR:   state_d = tms ? ST_EXIT2_DR   : ST_PAUSE_DR;
                ST_EXIT2_DR:   state_d = tms ? ST_UPDATE_DR  : ST_SHIFT_DR;
                ST_UPDATE_DR:  state_d = tms ? ST_SELECT_DR  : ST_RTI;
                ST_SELECT_IR:  state_d = tms ? ST_TLR        : ST_CAPTURE_IR;
                ST_CAPTURE_IR: state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
                ST_SHIFT_IR:   state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
                ST_EXIT1_IR:   state_d = tms ? ST_UPDATE_IR  : ST_PAUSE_IR;
                ST_PAUSE_IR:   state_d = tms ? ST_EXIT2_IR   : ST_PAUSE_IR;
                ST_EXIT2_IR:   state_d = tms ? ST_UPDATE_IR  : ST_SHIFT_IR;
                ST_UPDATE_IR:  state_d = tms ? ST_SELECT_DR  : ST_RTI;
                default:       state_d = ST_TLR;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/dtm.sv
// JTAG Debug Transport Module: oversamples the JTAG pins on clk, runs the TAP,
// holds IDCODE/DTMCS/DMI/BYPASS registers and turns each DMI scan into a single
// dmi_valid/dmi_ready request towards the debug module.
module dtm
    import dtm_defs::*;
#(
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0DB3,
    parameter int          ABITS       = 7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);

    localparam int DMI_W = ABITS + 34;

    logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic                   tck_prev_q, tck_prev_d;
    logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;

    logic [3:0]       tap_state;
    logic             capture_ir, shift_ir, update_ir;
    logic             capture_dr, shift_dr, update_dr;

    logic [4:0]       ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DMI_W-1:0] dr_sr_q, dr_sr_d;
    logic [1:0]       dmistat_q, dmistat_d;
    logic [ABITS-1:0] addr_last_q, addr_last_d;
    logic [31:0]      rdata_last_q, rdata_last_d;
    logic             tdo_q, tdo_d;
    logic             dmi_valid_q, dmi_valid_d;
    logic             dmi_write_q, dmi_write_d;
    logic [ABITS-1:0] dmi_addr_q, dmi_addr_d;
    logic [31:0]      dmi_wdata_q, dmi_wdata_d;

    dr_sel_e          dr_sel;
    logic             handshake;
    logic [1:0]       cap_status;
    logic [1:0]       dr_op;
    logic [31:0]      dtmcs_val;

    // All three pins share one synchroniser depth so tms/tdi stay aligned with tck.
    always_comb begin
        tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], jtag_tck};
        tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], jtag_tms};
        tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi};
        tck_prev_d = tck_sync_q[SYNC_STAGES-1];
    end

    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    jtag_tap_fsm u_tap (
        .clk        (clk),
        .resetn     (resetn),
        .tck_rise   (tck_rise),
        .tms        (tms_s),
        .state      (tap_state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign dr_sel     = decode_ir(ir_q);
    assign handshake  = dmi_valid_q & dmi_ready;
    assign cap_status = (dmi_valid_q || dmistat_q == DMI_STAT_BUSY) ? DMI_STAT_BUSY : dmistat_q;
    assign dr_op      = dr_sr_q[1:0];
    assign dtmcs_val  = {14'b0, 2'b0, 1'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};

    // IR/DR scan chains, DMI request/handshake bookkeeping and the tdo driver.
    always_comb begin
        ir_d         = ir_q;
        ir_sr_d      = ir_sr_q;
        dr_sr_d      = dr_sr_q;
        dmistat_d    = dmistat_q;
        addr_last_d  = addr_last_q;
        rdata_last_d = rdata_last_q;
        tdo_d        = tdo_q;
        dmi_valid_d  = dmi_valid_q;
        dmi_write_d  = dmi_write_q;
        dmi_addr_d   = dmi_addr_q;
        dmi_wdata_d  = dmi_wdata_q;

        if (capture_ir) ir_sr_d = 5'b00001;
        if (shift_ir)   ir_sr_d = {tdi_s, ir_sr_q[4:1]};
        if (update_ir)  ir_d    = ir_sr_q;
        if (tap_state == TAP_TLR) ir_d = IR_IDCODE;

        if (capture_dr) begin
            case (dr_sel)
                DR_IDCODE: dr_sr_d = DMI_W'(IDCODE_VAL);
                DR_DTMCS:  dr_sr_d = DMI_W'(dtmcs_val);
                DR_DMI:    dr_sr_d = {addr_last_q, rdata_last_q, cap_status};
                default:   dr_sr_d = '0;
            endcase
        end

        if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE, DR_DTMCS: dr_sr_d = DMI_W'({tdi_s, dr_sr_q[31:1]});
                DR_DMI:              dr_sr_d = {tdi_s, dr_sr_q[DMI_W-1:1]};
                default:             dr_sr_d = DMI_W'(tdi_s);
            endcase
        end

        // The handshake is resolved before Update-DR so a same-cycle scan sees the slot free.
        if (handshake) begin
            dmi_valid_d = 1'b0;
            addr_last_d = dmi_addr_q;
            if (!dmi_write_q) rdata_last_d = dmi_rdata;
        end

        if (update_dr && dr_sel == DR_DMI) begin
            if (dmi_valid_q && !handshake) begin
                dmistat_d = DMI_STAT_BUSY;
            end else if (dmistat_q == DMI_STAT_OK &&
                         (dr_op == DMI_OP_READ || dr_op == DMI_OP_WRITE)) begin
                dmi_valid_d = 1'b1;
                dmi_write_d = (dr_op == DMI_OP_WRITE);
                dmi_addr_d  = dr_sr_q[DMI_W-1:34];
                dmi_wdata_d = dr_sr_q[33:2];
            end
        end

        if (update_dr && dr_sel == DR_DTMCS) begin
            if (dr_sr_q[16] || dr_sr_q[17]) dmistat_d   = DMI_STAT_OK;
            if (dr_sr_q[17])                dmi_valid_d = 1'b0;
        end

        if (tck_fall) begin
            if (tap_state == TAP_SHIFT_IR)      tdo_d = ir_sr_q[0];
            else if (tap_state == TAP_SHIFT_DR) tdo_d = dr_sr_q[0];
        end
    end

    // Every flop in the block; reset clears in-flight requests immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tck_sync_q   <= '0;
            tms_sync_q   <= '0;
            tdi_sync_q   <= '0;
            tck_prev_q   <= 1'b0;
            ir_q         <= IR_IDCODE;
            ir_sr_q      <= '0;
            dr_sr_q      <= '0;
            dmistat_q    <= DMI_STAT_OK;
            addr_last_q  <= '0;
            rdata_last_q <= '0;
            tdo_q        <= 1'b0;
            dmi_valid_q  <= 1'b0;
            dmi_write_q  <= 1'b0;
            dmi_addr_q   <= '0;
            dmi_wdata_q  <= '0;
        end else begin
            tck_sync_q   <= tck_sync_d;
            tms_sync_q   <= tms_sync_d;
            tdi_sync_q   <= tdi_sync_d;
            tck_prev_q   <= tck_prev_d;
            ir_q         <= ir_d;
            ir_sr_q      <= ir_sr_d;
            dr_sr_q      <= dr_sr_d;
            dmistat_q    <= dmistat_d;
            addr_last_q  <= addr_last_d;
            rdata_last_q <= rdata_last_d;
            tdo_q        <= tdo_d;
            dmi_valid_q  <= dmi_valid_d;
            dmi_write_q  <= dmi_write_d;
            dmi_addr_q   <= dmi_addr_d;
            dmi_wdata_q  <= dmi_wdata_d;
        end
    end

    assign jtag_tdo  = tdo_q;
    assign dmi_valid = dmi_valid_q;
    assign dmi_write = dmi_write_q;
    assign dmi_addr  = dmi_addr_q;
    assign dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_dtm.sv
// Testbench for dtm: drives JTAG scans pin by pin, acts as a simple debug module
// on the DMI side, and checks scan-out data and DMI requests against queued
// hand-computed expectations.
`timescale 1ns/1ps
module tb_dtm;

    localparam int CLK_HALF = 5;
    localparam int TCK_HALF = 60;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } dmi_req_t;

    logic        clk;
    logic        resetn;
    logic        jtag_tck;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;
    logic        dmi_valid;
    logic        dmi_ready;
    logic        dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] expScan[$];
    string       expScanName[$];
    logic [63:0] obsScan[$];
    dmi_req_t    expDmi[$];
    event        scanDone;

    dtm dut (
        .clk       (clk),
        .resetn    (resetn),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo),
        .dmi_valid (dmi_valid),
        .dmi_ready (dmi_ready),
        .dmi_write (dmi_write),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    // Watchdog so a stuck run still terminates loudly.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One tck period: set tms/tdi, sample tdo at the end of the low phase, pulse tck.
    task automatic applyStimulus(input logic tmsV, input logic tdiV, output logic tdoV);
        jtag_tms = tmsV;
        jtag_tdi = tdiV;
        #TCK_HALF;
        tdoV = jtag_tdo;
        jtag_tck = 1'b1;
        #TCK_HALF;
        jtag_tck = 1'b0;
    endtask

    // DR scan from Run-Test/Idle back to Run-Test/Idle.
    task automatic scanDr(input int n, input logic [63:0] din, input logic [63:0] expv, input string name);
        logic        s;
        logic [63:0] dout;
        expScan.push_back(expv);
        expScanName.push_back(name);
        dout = '0;
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        for (int k = 0; k < n; k++) begin
            applyStimulus(k == n - 1, din[k], s);
            dout[k] = s;
        end
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        obsScan.push_back(dout);
        -> scanDone;
    endtask

    // IR scan from Run-Test/Idle; captured IR out is always 5'b00001.
    task automatic scanIr(input logic [4:0] ir, input string name);
        logic        s;
        logic [63:0] dout;
        expScan.push_back(64'h01);
        expScanName.push_back(name);
        dout = '0;
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k == 4, ir[k], s);
            dout[k] = s;
        end
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        obsScan.push_back(dout);
        -> scanDone;
    endtask

    task automatic waitValid(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dmi_valid) break;
        end
        checkOutput(name, 64'(dmi_valid), 64'h1);
    endtask

    // Debug-module side: accept the pending request with the given read data.
    task automatic respondDmi(input logic [31:0] rdata, input string name);
        @(posedge clk);
        #2;
        dmi_ready = 1'b1;
        dmi_rdata = rdata;
        @(posedge clk);
        #2;
        dmi_ready = 1'b0;
        dmi_rdata = 32'h0;
        @(negedge clk);
        checkOutput(name, 64'(dmi_valid), 64'h0);
    endtask

    // Scan monitor: compares each completed scan against the queued expectation.
    initial begin
        logic [63:0] obs;
        logic [63:0] exp;
        string       nm;
        forever begin
            @(scanDone);
            while (obsScan.size() > 0) begin
                obs = obsScan.pop_front();
                if (expScan.size() == 0) begin
                    checkOutput("scan_unexpected", obs, 64'hX);
                end else begin
                    exp = expScan.pop_front();
                    nm  = expScanName.pop_front();
                    checkOutput(nm, obs, exp);
                end
            end
        end
    end

    // DMI monitor: checks each new request and its stability at the handshake.
    initial begin
        logic     seen;
        dmi_req_t cur;
        seen = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (dmi_valid && !seen) begin
                seen = 1'b1;
                if (expDmi.size() == 0) begin
                    checkOutput("dmi_unexpected_req", {dmi_write, dmi_addr, dmi_wdata}, 64'h0);
                end else begin
                    cur = expDmi.pop_front();
                    checkOutput("dmi_req", {dmi_write, dmi_addr, dmi_wdata}, 64'(cur));
                end
            end
            if (dmi_valid && dmi_ready) begin
                checkOutput("dmi_stable_at_handshake", {dmi_write, dmi_addr, dmi_wdata}, 64'(cur));
            end
            if (!dmi_valid) seen = 1'b0;
        end
    end

    // Directed scenario sequence.
    initial begin
        logic s;
        jtag_tck  = 1'b0;
        jtag_tms  = 1'b1;
        jtag_tdi  = 1'b0;
        dmi_ready = 1'b0;
        dmi_rdata = 32'h0;
        resetn    = 1'b0;
        #23;
        checkOutput("reset_tdo",       64'(jtag_tdo),  64'h0);
        checkOutput("reset_dmi_valid", 64'(dmi_valid), 64'h0);
        checkOutput("reset_dmi_write", 64'(dmi_write), 64'h0);
        checkOutput("reset_dmi_addr",  64'(dmi_addr),  64'h0);
        checkOutput("reset_dmi_wdata", 64'(dmi_wdata), 64'h0);
        resetn = 1'b1;
        #40;

        repeat (5) applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        scanDr(32, 64'h0, 64'h1000_0DB3, "idcode_after_tlr");

        scanIr(5'h10, "ir_capture_dtmcs");
        scanDr(32, 64'h0, 64'h0000_1071, "dtmcs_capture");

        scanIr(5'h11, "ir_capture_dmi");
        expDmi.push_back('{write: 1'b1, addr: 7'h10, wdata: 32'h1});
        scanDr(41, 64'({7'h10, 32'h1, 2'd2}), 64'h0, "dmi_write_capture");
        waitValid("write_valid");
        repeat (5) @(negedge clk);
        checkOutput("write_valid_held", 64'(dmi_valid), 64'h1);
        respondDmi(32'hFFFF_FFFF, "write_valid_drop");

        expDmi.push_back('{write: 1'b0, addr: 7'h04, wdata: 32'h0});
        scanDr(41, 64'({7'h04, 32'h0, 2'd1}), 64'({7'h10, 32'h0, 2'd0}), "dmi_read_capture");
        waitValid("read_valid");
        respondDmi(32'hCAFE_F00D, "read_valid_drop");
        scanDr(41, 64'h0, 64'({7'h04, 32'hCAFE_F00D, 2'd0}), "dmi_read_result");

        expDmi.push_back('{write: 1'b1, addr: 7'h05, wdata: 32'h55});
        scanDr(41, 64'({7'h05, 32'h55, 2'd2}), 64'({7'h04, 32'hCAFE_F00D, 2'd0}), "dmi_write2_capture");
        waitValid("write2_valid");
        scanDr(41, 64'({7'h06, 32'h0, 2'd1}), 64'({7'h04, 32'hCAFE_F00D, 2'd3}), "dmi_busy_capture");
        respondDmi(32'hDEAD_0000, "write2_valid_drop");
        scanDr(41, 64'({7'h07, 32'h0, 2'd1}), 64'({7'h05, 32'hCAFE_F00D, 2'd3}), "dmi_sticky_busy");
        repeat (10) @(negedge clk);
        checkOutput("sticky_no_request", 64'(dmi_valid), 64'h0);

        scanIr(5'h10, "ir_capture_dtmcs2");
        scanDr(32, 64'h0001_0000, 64'h0000_1C71, "dtmcs_busy_capture");
        scanIr(5'h11, "ir_capture_dmi2");
        scanDr(41, 64'h0, 64'({7'h05, 32'hCAFE_F00D, 2'd0}), "dmi_after_dmireset");

        expDmi.push_back('{write: 1'b1, addr: 7'h08, wdata: 32'h1234});
        scanDr(41, 64'({7'h08, 32'h1234, 2'd2}), 64'({7'h05, 32'hCAFE_F00D, 2'd0}), "dmi_write3_capture");
        waitValid("write3_valid");
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_dmi_valid", 64'(dmi_valid), 64'h0);
        checkOutput("midreset_dmi_addr",  64'(dmi_addr),  64'h0);
        checkOutput("midreset_dmi_wdata", 64'(dmi_wdata), 64'h0);
        #30;
        resetn = 1'b1;
        #40;

        applyStimulus(1'b0, 1'b0, s);
        scanDr(32, 64'h0, 64'h1000_0DB3, "idcode_after_reset");
        scanIr(5'h1f, "ir_capture_bypass");
        scanDr(8, 64'hA5, 64'h4A, "bypass_8bit");
        scanIr(5'h05, "ir_capture_unknown");
        scanDr(4, 64'hF, 64'hE, "unknown_ir_bypass");

        repeat (20) @(negedge clk);
        checkOutput("scan_queue_drained", 64'(expScan.size()), 64'h0);
        checkOutput("dmi_queue_drained",  64'(expDmi.size()),  64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
